// File: rtl/wb_pkg.sv
// Shared definitions for the eviction write-back buffer: drain FSM state
// encoding and the default widths that must match the LRU data cache.
package wb_pkg;

    localparam int WB_DEPTH       = 4;
    localparam int WB_TAG_WIDTH   = 4;
    localparam int WB_VALUE_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_snoop_match.sv
// Snoop lookup for the write-back buffer: compares a tag against every valid
// entry and returns the value of the youngest match (closest to the tail).
module wb_snoop_match #(
    parameter int DEPTH       = 4,
    parameter int TAG_WIDTH   = 4,
    parameter int VALUE_WIDTH = 32
) (
    input  logic [DEPTH*TAG_WIDTH-1:0]   tags,
    input  logic [DEPTH*VALUE_WIDTH-1:0] values,
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [TAG_WIDTH-1:0]         snoop_tag,
    output logic                         hit,
    output logic [VALUE_WIDTH-1:0]       value
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;

    // Per-entry tag compare, qualified by the valid bit
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i*TAG_WIDTH +: TAG_WIDTH] == snoop_tag);
        end
    end

    // Walk from head (oldest) to tail (youngest); later matches overwrite earlier
    always_comb begin
        hit   = 1'b0;
        value = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (match[idx]) begin
                hit   = 1'b1;
                value = values[idx*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Eviction write-back buffer: captures dirty lines from the cache into a
// circular FIFO and drains them to lower memory over a req/ack handshake.
// Optional snoop forwarding is built when WB_SNOOP_FORWARD_EN is defined.
//
// state | meaning
// IDLE  | nothing requested; start a request once the FIFO is non-empty
// REQ   | mem_req high, head entry presented; pop on mem_ack
// GAP   | one-cycle mem_req low after each accepted write
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH       = WB_DEPTH,
    parameter int TAG_WIDTH   = WB_TAG_WIDTH,
    parameter int VALUE_WIDTH = WB_VALUE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TAG_WIDTH-1:0]     push_tag,
    input  logic [VALUE_WIDTH-1:0]   push_value,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     mem_req,
    output logic [TAG_WIDTH-1:0]     mem_tag,
    output logic [VALUE_WIDTH-1:0]   mem_value,
    input  logic                     mem_ack,
    input  logic [TAG_WIDTH-1:0]     snoop_tag,
    output logic                     snoop_hit,
    output logic [VALUE_WIDTH-1:0]   snoop_value
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_WIDTH-1:0]   tag_mem [DEPTH];
    logic [VALUE_WIDTH-1:0] val_mem [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count_q;
    wb_state_e              state;
    logic                   mem_req_q;
    logic                   overflow_q;
    logic                   push_ok;
    logic                   pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign mem_req  = mem_req_q;

    // A full buffer drops the push even if the head is popped this same cycle
    assign push_ok = push && !full;
    assign pop     = (state == REQ) && mem_ack;

    // Head entry is only presented while a request is outstanding
    assign mem_tag   = mem_req_q ? tag_mem[head] : '0;
    assign mem_value = mem_req_q ? val_mem[head] : '0;

    // Entry storage and per-entry valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                val_mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
            end
            if (push_ok) begin
                tag_mem[tail] <= push_tag;
                val_mem[tail] <= push_value;
                valid[tail]   <= 1'b1;
            end
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (push && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Drain FSM with registered mem_req
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state     <= GAP;
                        mem_req_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (!empty) begin
                        state     <= REQ;
                        mem_req_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_SNOOP_FORWARD_EN
    logic [DEPTH*TAG_WIDTH-1:0]   tags_flat;
    logic [DEPTH*VALUE_WIDTH-1:0] values_flat;

    // Flatten storage for the snoop comparator
    always_comb begin
        tags_flat   = '0;
        values_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tags_flat[i*TAG_WIDTH +: TAG_WIDTH]       = tag_mem[i];
            values_flat[i*VALUE_WIDTH +: VALUE_WIDTH] = val_mem[i];
        end
    end

    wb_snoop_match #(
        .DEPTH       (DEPTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_snoop (
        .tags      (tags_flat),
        .values    (values_flat),
        .valid     (valid),
        .head      (head),
        .snoop_tag (snoop_tag),
        .hit       (snoop_hit),
        .value     (snoop_value)
    );
`else
    // Without forwarding the cache waits for empty before a memory read
    logic [TAG_WIDTH-1:0] unused_snoop_tag;
    assign unused_snoop_tag = snoop_tag;
    assign snoop_hit        = 1'b0;
    assign snoop_value      = '0;
`endif

endmodule
